// File: rtl/video_pkg.sv
// Shared types for the video line-fetch path: scheduler states, page geometry
// and the job descriptor carried from acceptance to completion.
package video_pkg;

    localparam int PAGE_W     = 12;
    localparam int PAGE_BYTES = 1 << PAGE_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        FINISH
    } state_t;

    // Held at full mover width so the cursor drives mv_* directly; upper bits
    // of dest and len are kept at zero by construction.
    typedef struct packed {
        logic [63:0] src;
        logic [63:0] dest;
        logic [63:0] len;
        logic        owner;   // 0: primary (req0), 1: auxiliary (req1)
    } job_t;

endpackage

// File: rtl/chunk_calc.sv
// Size of the next mover transfer: min(remaining, MAX_CHUNK, bytes left in
// the current 4 KiB source page), forced to an 8-byte multiple.
module chunk_calc
    import video_pkg::*;
#(
    parameter int MAX_CHUNK = 512
) (
    input  logic [PAGE_W-1:0] src_off,
    input  logic [63:0]       remaining,
    output logic [PAGE_W:0]   chunk
);

    localparam int CW = PAGE_W + 1;

    logic [CW-1:0] page_rem;
    logic [CW-1:0] cap;

    always_comb begin
        page_rem = CW'(PAGE_BYTES) - {1'b0, src_off};
        cap      = (page_rem < CW'(MAX_CHUNK)) ? page_rem : CW'(MAX_CHUNK);
        if (remaining < 64'(cap)) begin
            chunk = remaining[CW-1:0];
        end else begin
            chunk = cap;
        end
        chunk[2:0] = 3'b000;
    end

endmodule

// File: rtl/line_fetch_scheduler.sv
// Arbitrates primary/auxiliary line fetches onto one data mover, splitting each
// job into page-safe chunks and flagging a primary fetch that misses its line.
module line_fetch_scheduler
    import video_pkg::*;
#(
    parameter int MAX_CHUNK = 512,
    parameter int LEN_W     = 15,
    parameter int DEST_W    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sched_en,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [63:0]       req0_src,
    input  logic [DEST_W-1:0] req0_dest,
    input  logic [LEN_W-1:0]  req0_len,
    output logic              req0_done,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [63:0]       req1_src,
    input  logic [DEST_W-1:0] req1_dest,
    input  logic [LEN_W-1:0]  req1_len,
    output logic              req1_done,
    input  logic              line_start,
    output logic              late,
    input  logic              late_clr,
    output logic [63:0]       mv_src,
    output logic [63:0]       mv_dest,
    output logic [63:0]       mv_len,
    output logic              mv_en,
    input  logic              mv_done,
    output logic              busy
);

    localparam int CW = PAGE_W + 1;

    state_t           state_reg, state_next;
    job_t             cur_reg, cur_next;
    job_t             sel_job;
    logic [CW-1:0]    chunk_reg, chunk_next, chunk_calc_out;
    logic             grant_reg, grant_next;
    logic             ready0_reg, ready0_next, ready1_reg, ready1_next;
    logic             done0_reg, done0_next, done1_reg, done1_next;
    logic             late_reg, late_next;
    logic [63:0]      chunk64;
    logic [DEST_W-1:0] dest_sum;
    logic             owner0_active;

    chunk_calc #(
        .MAX_CHUNK (MAX_CHUNK)
    ) u_chunk_calc (
        .src_off   (cur_next.src[PAGE_W-1:0]),
        .remaining (cur_next.len),
        .chunk     (chunk_calc_out)
    );

    assign chunk64  = {{(64-CW){1'b0}}, chunk_reg};
    assign dest_sum = cur_reg.dest[DEST_W-1:0] + DEST_W'(chunk_reg);

    // Fixed priority: req0 wins whenever it is valid.
    always_comb begin
        sel_job       = '0;
        sel_job.owner = ~req0_valid;
        sel_job.src   = (req0_valid ? req0_src : req1_src) & ~64'h7;
        sel_job.dest  = {{(64-DEST_W){1'b0}}, (req0_valid ? req0_dest : req1_dest)} & ~64'h7;
        sel_job.len   = {{(64-LEN_W){1'b0}}, (req0_valid ? req0_len : req1_len)} & ~64'h7;
    end

    always_comb begin
        state_next  = state_reg;
        cur_next    = cur_reg;
        chunk_next  = chunk_reg;
        grant_next  = 1'b0;
        ready0_next = 1'b0;
        ready1_next = 1'b0;
        done0_next  = 1'b0;
        done1_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // The ready pulse cycle is spent here; the job leaves IDLE after it.
                if (grant_reg) begin
                    state_next = (cur_reg.len == 64'd0) ? FINISH : ISSUE;
                end else if (sched_en && (req0_valid || req1_valid)) begin
                    cur_next    = sel_job;
                    grant_next  = 1'b1;
                    ready0_next = req0_valid;
                    ready1_next = ~req0_valid;
                end
            end
            ISSUE: begin
                if (mv_done) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!mv_done) begin
                    cur_next.src  = cur_reg.src + chunk64;
                    cur_next.dest = {{(64-DEST_W){1'b0}}, dest_sum};
                    cur_next.len  = cur_reg.len - chunk64;
                    state_next    = (cur_next.len == 64'd0) ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                done0_next = ~cur_reg.owner;
                done1_next = cur_reg.owner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Chunk is frozen on ISSUE entry so mv_len never moves under mv_en.
        if (state_next == ISSUE && state_reg != ISSUE) begin
            chunk_next = chunk_calc_out;
        end
    end

    assign owner0_active = ~cur_reg.owner && ((state_reg != IDLE) || grant_reg);

    always_comb begin
        late_next = late_reg;
        if (late_clr) begin
            late_next = 1'b0;
        end
        if (line_start && (owner0_active || (req0_valid && !ready0_reg))) begin
            late_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cur_reg    <= '0;
            chunk_reg  <= '0;
            grant_reg  <= 1'b0;
            ready0_reg <= 1'b0;
            ready1_reg <= 1'b0;
            done0_reg  <= 1'b0;
            done1_reg  <= 1'b0;
            late_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cur_reg    <= cur_next;
            chunk_reg  <= chunk_next;
            grant_reg  <= grant_next;
            ready0_reg <= ready0_next;
            ready1_reg <= ready1_next;
            done0_reg  <= done0_next;
            done1_reg  <= done1_next;
            late_reg   <= late_next;
        end
    end

    assign req0_ready = ready0_reg;
    assign req1_ready = ready1_reg;
    assign req0_done  = done0_reg;
    assign req1_done  = done1_reg;
    assign late       = late_reg;
    assign mv_src     = cur_reg.src;
    assign mv_dest    = cur_reg.dest;
    assign mv_len     = chunk64;
    assign mv_en      = (state_reg == ISSUE);
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Directed bench for line_fetch_scheduler with a behavioural mover that logs
// every transfer it is handed.
module tb_line_fetch_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        sched_en;
    logic        req0_valid, req0_ready, req0_done;
    logic [63:0] req0_src;
    logic [14:0] req0_dest, req0_len;
    logic        req1_valid, req1_ready, req1_done;
    logic [63:0] req1_src;
    logic [14:0] req1_dest, req1_len;
    logic        line_start, late, late_clr;
    logic [63:0] mv_src, mv_dest, mv_len;
    logic        mv_en;
    logic        mv_done = 1'b0;
    logic        busy;
    logic        mover_hold;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] xfer_src  [0:63];
    logic [63:0] xfer_dest [0:63];
    logic [63:0] xfer_len  [0:63];
    int xfer_cnt  = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;
    int r1_cnt    = 0;
    int en_rises  = 0;
    logic en_prev = 1'b0;

    line_fetch_scheduler #(
        .MAX_CHUNK (512),
        .LEN_W     (15),
        .DEST_W    (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sched_en   (sched_en),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_src   (req0_src),
        .req0_dest  (req0_dest),
        .req0_len   (req0_len),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_src   (req1_src),
        .req1_dest  (req1_dest),
        .req1_len   (req1_len),
        .req1_done  (req1_done),
        .line_start (line_start),
        .late       (late),
        .late_clr   (late_clr),
        .mv_src     (mv_src),
        .mv_dest    (mv_dest),
        .mv_len     (mv_len),
        .mv_en      (mv_en),
        .mv_done    (mv_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Mover: answers mv_en with mv_done two cycles later, drops it after mv_en falls.
    always begin
        @(posedge clk);
        #1;
        if (mv_en && !mv_done && !mover_hold) begin
            if (xfer_cnt < 64) begin
                xfer_src[xfer_cnt]  = mv_src;
                xfer_dest[xfer_cnt] = mv_dest;
                xfer_len[xfer_cnt]  = mv_len;
            end
            xfer_cnt = xfer_cnt + 1;
            $display("xfer %0d src=0x%0h dest=0x%0h len=%0d", xfer_cnt - 1, mv_src, mv_dest, mv_len);
            repeat (2) @(posedge clk);
            #1;
            mv_done = 1'b1;
        end else if (!mv_en && mv_done) begin
            @(posedge clk);
            #1;
            mv_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (req0_done) done0_cnt = done0_cnt + 1;
        if (req1_done) done1_cnt = done1_cnt + 1;
        if (req1_ready) r1_cnt = r1_cnt + 1;
        if (mv_en && !en_prev) en_rises = en_rises + 1;
        en_prev = mv_en;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit which, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            seen = which ? req1_done : req0_done;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic chk_xfer(input string tag, input int idx,
                            input logic [63:0] src, input logic [63:0] dest, input logic [63:0] len);
        chk({tag, "_src"},  xfer_src[idx],  src);
        chk({tag, "_dest"}, xfer_dest[idx], dest);
        chk({tag, "_len"},  xfer_len[idx],  len);
    endtask

    task automatic post0(input logic [63:0] src, input logic [14:0] dest, input logic [14:0] len);
        req0_src = src; req0_dest = dest; req0_len = len; req0_valid = 1'b1;
    endtask

    initial begin
        int base;
        int snap;
        rst = 1'b1; sched_en = 1'b1; mover_hold = 1'b0;
        req0_valid = 1'b0; req0_src = '0; req0_dest = '0; req0_len = '0;
        req1_valid = 1'b0; req1_src = '0; req1_dest = '0; req1_len = '0;
        line_start = 1'b0; late_clr = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_mv_en", 64'(mv_en), 64'd0);
        chk("rst_ready", 64'({req0_ready, req1_ready, req0_done, req1_done, late}), 64'd0);
        chk("rst_mv_len", mv_len, 64'd0);
        chk("rst_mv_src", mv_src, 64'd0);
        rst = 1'b0;

        // Five 512-byte chunks across a page-aligned 2560-byte line
        @(negedge clk);
        base = xfer_cnt;
        post0(64'h1000, 15'h0, 15'd2560);
        @(negedge clk);
        chk("t1_ready0", 64'(req0_ready), 64'd1);
        chk("t1_busy_grant", 64'(busy), 64'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_mv_en", 64'(mv_en), 64'd1);
        chk("t1_ready_pulse", 64'(req0_ready), 64'd0);
        chk("t1_mv_len0", mv_len, 64'd512);
        wait_done(1'b0, "t1_done0");
        chk("t1_nxfer", 64'(xfer_cnt - base), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk_xfer("t1_x", base + i, 64'h1000 + 64'(i * 512), 64'(i * 512), 64'd512);
        end
        @(negedge clk);
        chk("t1_busy_after", 64'(busy), 64'd0);

        // Page crossing: 128 bytes up to 0x1000, then 384
        base = xfer_cnt;
        snap = done0_cnt;
        post0(64'h0F80, 15'h0, 15'd512);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_done(1'b0, "t2_done0");
        chk("t2_nxfer", 64'(xfer_cnt - base), 64'd2);
        chk_xfer("t2_x0", base,     64'h0F80, 64'd0,   64'd128);
        chk_xfer("t2_x1", base + 1, 64'h1000, 64'd128, 64'd384);
        @(negedge clk);
        chk("t2_done_once", 64'(done0_cnt - snap), 64'd1);

        // Simultaneous requests: req0 first, req1 only after req0_done
        base = xfer_cnt;
        snap = r1_cnt;
        post0(64'h2000, 15'h40, 15'd16);
        req1_src = 64'h3000; req1_dest = 15'h100; req1_len = 15'd24; req1_valid = 1'b1;
        @(negedge clk);
        chk("t3_ready0", 64'(req0_ready), 64'd1);
        chk("t3_ready1_low", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0;
        wait_done(1'b0, "t3_done0");
        chk("t3_no_r1_before", 64'(r1_cnt - snap), 64'd0);
        @(negedge clk);
        chk("t3_ready1", 64'(req1_ready), 64'd1);
        req1_valid = 1'b0;
        wait_done(1'b1, "t3_done1");
        chk("t3_nxfer", 64'(xfer_cnt - base), 64'd2);
        chk_xfer("t3_x0", base,     64'h2000, 64'h40,  64'd16);
        chk_xfer("t3_x1", base + 1, 64'h3000, 64'h100, 64'd24);

        // Zero length: ready, done two cycles later, mover untouched
        @(negedge clk);
        snap = en_rises;
        post0(64'h9000, 15'h0, 15'd0);
        @(negedge clk);
        chk("t4_ready0", 64'(req0_ready), 64'd1);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t4_busy_finish", 64'(busy), 64'd1);
        chk("t4_no_done_yet", 64'(req0_done), 64'd0);
        @(negedge clk);
        chk("t4_done0", 64'(req0_done), 64'd1);
        chk("t4_no_mv_en", 64'(en_rises - snap), 64'd0);

        // Unaligned fields are masked to 8-byte multiples (len 0x13 -> 0x10)
        @(negedge clk);
        base = xfer_cnt;
        req1_src = 64'h4003; req1_dest = 15'h7; req1_len = 15'h13; req1_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_done(1'b1, "t5_done1");
        chk("t5_nxfer", 64'(xfer_cnt - base), 64'd1);
        chk_xfer("t5_x0", base, 64'h4000, 64'h0, 64'h10);

        // late: set while primary job is in ISSUE; set beats clear
        @(negedge clk);
        mover_hold = 1'b1;
        post0(64'h5000, 15'h0, 15'd64);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t6_mv_en", 64'(mv_en), 64'd1);
        chk("t6_late_before", 64'(late), 64'd0);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        chk("t6_late_set", 64'(late), 64'd1);
        repeat (3) @(negedge clk);
        chk("t6_late_sticky", 64'(late), 64'd1);
        chk("t6_mv_stable", mv_len, 64'd64);
        line_start = 1'b1; late_clr = 1'b1;
        @(negedge clk);
        line_start = 1'b0; late_clr = 1'b0;
        chk("t6_set_wins", 64'(late), 64'd1);
        late_clr = 1'b1;
        @(negedge clk);
        late_clr = 1'b0;
        chk("t6_late_clr", 64'(late), 64'd0);
        mover_hold = 1'b0;
        wait_done(1'b0, "t6_done0");

        // late from a pending req0 held off by sched_en=0
        @(negedge clk);
        sched_en = 1'b0;
        post0(64'h8000, 15'h0, 15'd8);
        repeat (3) @(negedge clk);
        chk("t7_no_accept", 64'({req0_ready, busy}), 64'd0);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        chk("t7_late_pending", 64'(late), 64'd1);
        late_clr = 1'b1;
        @(negedge clk);
        late_clr = 1'b0;
        chk("t7_late_clr", 64'(late), 64'd0);
        sched_en = 1'b1;
        @(negedge clk);
        chk("t7_ready0", 64'(req0_ready), 64'd1);
        req0_valid = 1'b0;
        wait_done(1'b0, "t7_done0");

        // Asynchronous reset in ISSUE discards the job
        @(negedge clk);
        mover_hold = 1'b1;
        post0(64'h6000, 15'h0, 15'd64);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t8_mv_en_pre", 64'(mv_en), 64'd1);
        snap = done0_cnt;
        #1;
        rst = 1'b1;
        #1;
        chk("t8_rst_mv_en", 64'(mv_en), 64'd0);
        chk("t8_rst_busy", 64'(busy), 64'd0);
        chk("t8_rst_hs", 64'({req0_ready, req1_ready, req0_done, req1_done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mover_hold = 1'b0;
        base = xfer_cnt;
        req1_src = 64'h7000; req1_dest = 15'h20; req1_len = 15'd32; req1_valid = 1'b1;
        @(negedge clk);
        chk("t8_ready1", 64'(req1_ready), 64'd1);
        req1_valid = 1'b0;
        wait_done(1'b1, "t8_done1");
        chk("t8_nxfer", 64'(xfer_cnt - base), 64'd1);
        chk_xfer("t8_x0", base, 64'h7000, 64'h20, 64'd32);
        repeat (2) @(negedge clk);
        chk("t8_no_done0", 64'(done0_cnt - snap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_fetch_scheduler.md
Name: line_fetch_scheduler

Overview:
- Sequences the line-buffer DMA data mover and shares it between two fetch requesters: req0 is the primary scan-out line refill, req1 is the auxiliary plane (cursor/overlay).
- Each accepted job is split into mover transfers of at most MAX_CHUNK bytes, none crossing a 4 KiB source boundary.
- The block drives the mover's level en/done handshake and reports completion and late-line errors.
- It sits in the aclk domain between the video timing logic and nasti_data_mover.

Parameters:
- MAX_CHUNK, 512, max bytes per mover transfer; power of two, ≥8, ≤4096.
- LEN_W, 15, job length width in bytes.
- DEST_W, 15, line-buffer byte address width.

Ports:
- clk  in  1  clock (aclk domain)
- rst  in  1  asynchronous reset, active-high
- sched_en  in  1  scheduling enable; low: no new job accepted
- req0_valid  in  1  primary job request
- req0_ready  out  1  primary job accepted this cycle
- req0_src  in  64  primary source byte address
- req0_dest  in  DEST_W  primary line-buffer byte address
- req0_len  in  LEN_W  primary length in bytes
- req0_done  out  1  one-cycle pulse, primary job complete
- req1_valid, req1_ready, req1_src, req1_dest, req1_len, req1_done: same as req0, auxiliary requester
- line_start  in  1  one-cycle pulse at each scanline deadline
- late  out  1  sticky: primary job still active at line_start
- late_clr  in  1  clears late
- mv_src  out  64  mover source address
- mv_dest  out  64  mover destination address, zero-extended from DEST_W
- mv_len  out  64  mover length, zero-extended
- mv_en  out  1  mover enable (level)
- mv_done  in  1  mover done (level)
- busy  out  1  job in progress

Behaviour:
- Reset values: every output 0; FSM in IDLE.
- Address/length alignment: src, dest and len have bits [2:0] forced to 0 at acceptance.
- States: IDLE, ISSUE, RELEASE, FINISH.
- IDLE:
  - If sched_en=1 and any valid is high, accept one job: assert that requester's ready for exactly one cycle and latch src/dest/len/owner.
  - req0 has fixed priority when both are valid.
  - After accepting, go to ISSUE; if the latched len is 0, go directly to FINISH.
- ISSUE:
  - On entry, compute chunk = min(remaining, MAX_CHUNK, 4096 − cur_src[11:0]).
  - Drive mv_src/mv_dest/mv_len stable and mv_en=1.
  - Wait for mv_done=1, then go to RELEASE.
- RELEASE:
  - Drive mv_en=0 and wait for mv_done=0.
  - Then update cur_src+=chunk, cur_dest+=chunk, remaining−=chunk.
  - If remaining=0, go to FINISH; else go to ISSUE.
- FINISH: pulse the owner's done for 1 cycle, then go to IDLE.
- Latency:
  - ready is asserted the cycle after valid is observed in IDLE.
  - mv_en rises the cycle after acceptance.
  - done pulses 1 cycle after the last mv_done fall.
- mv_* outputs change only when mv_en=0.
- sched_en deassertion mid-job: the current job runs to completion; no new job is accepted.
- busy=1 in every state except IDLE.
- late:
  - Set when line_start=1 and (owner=req0 and busy), or req0_valid is pending unaccepted.
  - late_clr and set in the same cycle: set wins.
- dest arithmetic wraps modulo 2^DEST_W. Length arithmetic never underflows (chunk ≤ remaining).
- Asynchronous reset mid-job:
  - mv_en drops immediately and the job is discarded; no done pulse.
  - The mover's own reset is the system's responsibility.
- A mover that never asserts mv_done hangs the FSM in ISSUE. This is intended: no timeout.

Decomposition:
- Shared package video_pkg holds:
  - the state enum (IDLE/ISSUE/RELEASE/FINISH);
  - PAGE_BYTES=4096;
  - a job struct {src, dest, len, owner}.
- Sub-module chunk_calc: combinational min(remaining, MAX_CHUNK, page remainder) with alignment masking.

Test Plan:
- req0 src=0x1000, dest=0, len=2560, MAX_CHUNK=512 → five mover transfers of 512, src 0x1000..0x1800, then one req0_done pulse.
- req0 src=0x0F80, len=512 → chunks 128 (src 0xF80) and 384 (src 0x1000); dest 0 then 128.
- req0 and req1 valid in the same IDLE cycle → req0 accepted first; req1_ready after req0_done; no interleaving of chunks.
- req0 len=0 → req0_ready, then req0_done two cycles later; mv_en never rises.
- line_start while a req0 job is in ISSUE → late=1 and stays 1. late_clr together with line_start keeps late=1; late_clr alone clears it.
- rst asserted during ISSUE with mv_en=1 → mv_en, busy, ready and done all 0 immediately; after release, the FSM accepts a new req1 normally.
